ysyx_25060170_imem_resp: RTL and testbench
==========================================

# ysyx_25060170_imem_resp

Instruction-memory responder: the memory end of the fetch interface driven by the IFU. It accepts one fetch address at a time over a valid/ready request channel and returns the 32-bit instruction word after a fixed configurable latency over a valid/ready response channel. It can discard an in-flight fetch when the core redirects (jump/flush). It sits between the IFU and the decode stage, backed by an internal word array that the testbench or boot logic fills through a simple write port.

## Interface
- `BASE_ADDR`, 32'h8000_0000, byte address of word 0 (matches the IFU reset PC)
- `MEM_WORDS`, 1024, number of 32-bit words in the array (power of two, 16..65536)
- `LATENCY`, 2, cycles from request acceptance to `rsp_valid` (1..15)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `req_valid`  in  1  fetch request present
- `req_ready`  out  1  responder can accept a request
- `req_addr`  in  32  fetch byte address
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_inst`  out  32  instruction word (0 when `rsp_err`)
- `rsp_err`  out  1  misaligned or out-of-range fetch
- `flush`  in  1  discard any outstanding or pending response
- `load_en`  in  1  write one word into the array
- `load_addr`  in  32  byte address for the write (same mapping as fetch)
- `load_data`  in  32  word to write

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: `req_ready` = 1. On `req_valid && req_ready` (accept):
  - index = (`req_addr` - `BASE_ADDR`) >> 2, 32-bit unsigned subtraction with wraparound.
  - err = (`req_addr[1:0]` != 0) or (index >= `MEM_WORDS`).
  - Capture inst = err ? 0 : mem[index] and err into output registers at the accept edge.
  - Load counter with `LATENCY`-1; go to RESP if `LATENCY` = 1, else WAIT.
- WAIT: `req_ready` = 0; counter decrements each cycle; at count 1 go to RESP next edge.
- RESP: `rsp_valid` = 1; `rsp_inst`/`rsp_err` held stable until `rsp_valid && rsp_ready`, then back to IDLE.
- `flush` = 1 in WAIT or RESP: return to IDLE next edge, no response delivered (even if `rsp_ready` = 1 that cycle, the handshake is void). In IDLE, `flush` has no effect; a request presented in the same cycle as `flush` while IDLE is accepted normally.
- Load port: when `load_en` = 1 and the address is aligned and in range, mem[index] is written at the rising edge; otherwise ignored. Writes are allowed in any state. A fetch accepted at the same edge as a write to the same word returns the old word.
- Memory contents are not reset.

## Timing
- During reset (`rst` = 0): `req_ready` = 0, `rsp_valid` = 0, `rsp_inst` = 0, `rsp_err` = 0, state IDLE, counter 0. `req_ready` is gated by `rst` and rises combinationally when `rst` deasserts.
- Request accepted at edge T: `rsp_valid` rises after edge T+`LATENCY`-1, first sampleable at edge T+`LATENCY`.
- Max throughput: one fetch per `LATENCY`+1 cycles with `rsp_ready` tied high; `req_ready` returns to 1 the cycle after the response handshake.
- Backpressure: `rsp_ready` = 0 holds RESP indefinitely with outputs stable.
- Reset asserted mid-operation: all state and outputs return to reset values immediately (asynchronously); the in-flight fetch is lost.
- `rsp_valid` never depends combinationally on `rsp_ready`; `req_ready` depends only on state and `rst`.

## Test plan
- Reset/idle: hold `rst` = 0 for 3 cycles, then release -> all outputs 0 during reset; `req_ready` = 1 after release; `rsp_valid` stays 0 with no request.
- Basic fetch, `LATENCY` = 2: load word 0x0000_0413 at 0x8000_0004, request 0x8000_0004 at edge T with `rsp_ready` = 1 -> `rsp_valid` = 1 sampled at T+2, `rsp_inst` = 0x0000_0413, `rsp_err` = 0; `req_ready` = 1 at T+3.
- Errors: request 0x8000_0002 -> response with `rsp_err` = 1, `rsp_inst` = 0; request 0x8000_1000 (`MEM_WORDS` = 1024) -> `rsp_err` = 1; request 0x7FFF_FFFC -> `rsp_err` = 1 (wraparound index).
- Backpressure: `rsp_ready` = 0 for 5 cycles after `rsp_valid` -> `rsp_valid`/`rsp_inst` stable all 5 cycles, `req_ready` = 0; raise `rsp_ready` -> one handshake, then IDLE.
- Flush: assert `flush` one cycle in WAIT, and separately in RESP with `rsp_ready` = 1 -> no response delivered, IDLE next cycle; following request to 0x8000_0000 returns mem[0] with normal latency.
- Async reset mid-fetch: drop `rst` between clock edges during WAIT -> `rsp_valid`, `req_ready` go 0 without a clock edge; after release a new fetch completes correctly.

Source files
------------

// File: rtl/ysyx_25060170_imem_resp.sv
// rtl/ysyx_25060170_imem_resp.sv - instruction-memory responder with fixed fetch latency
//
// Memory end of the IFU fetch interface. One fetch is accepted at a time on
// the request channel; the word (or an error) is returned LATENCY cycles later
// on the response channel and held until consumed. flush discards an
// in-flight fetch. The backing word array is filled through the load port.
// BASE_ADDR is expected to be word-aligned.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_valid  in   fetch request present
//   req_ready  out  responder idle and out of reset
//   req_addr   in   fetch byte address
//   rsp_valid  out  response present
//   rsp_ready  in   consumer takes the response
//   rsp_inst   out  fetched word (0 on error)
//   rsp_err    out  misaligned or out-of-range fetch
//   flush      in   drop any outstanding/pending response
//   load_en    in   write one word into the array
//   load_addr  in   byte address of the write
//   load_data  in   word to write

module ysyx_25060170_imem_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int         IDX_W    = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;

  logic [31:0] mem [MEM_WORDS];

  // Word offset from BASE_ADDR; any bit above the index field set means the
  // address is outside the array (including wraparound below BASE_ADDR).
  logic [29:0]      req_word_off;
  logic [IDX_W-1:0] req_idx;
  logic             req_err;
  logic [29:0]      load_word_off;
  logic [IDX_W-1:0] load_idx;
  logic             load_err;
  logic             accept;

  assign req_word_off  = req_addr[31:2] - BASE_ADDR[31:2];
  assign req_idx       = req_word_off[IDX_W-1:0];
  assign req_err       = (req_addr[1:0] != 2'b00) || (req_word_off[29:IDX_W] != '0);

  assign load_word_off = load_addr[31:2] - BASE_ADDR[31:2];
  assign load_idx      = load_word_off[IDX_W-1:0];
  assign load_err      = (load_addr[1:0] != 2'b00) || (load_word_off[29:IDX_W] != '0);

  assign req_ready = rst && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_inst  = inst_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Array is read here so a same-edge load returns the old word.
          inst_d  = req_err ? 32'h0 : mem[req_idx];
          err_d   = req_err;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // flush voids the handshake; either way nothing more is delivered.
        if (flush || rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_en && !load_err) begin
      mem[load_idx] <= load_data;
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_imem_resp.sv
// tb/tb_ysyx_25060170_imem_resp.sv - self-checking bench for ysyx_25060170_imem_resp

module tb_ysyx_25060170_imem_resp;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          WORDS = 1024;
  localparam int          LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  always #5 clk = ~clk;

  ysyx_25060170_imem_resp #(
    .BASE_ADDR(BASE),
    .MEM_WORDS(WORDS),
    .LATENCY  (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_inst (rsp_inst),
    .rsp_err  (rsp_err),
    .flush    (flush),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Transaction-level model: one outstanding fetch, its age in cycles since
  // acceptance, and the word/error it must return.
  logic [31:0] mmem [WORDS];
  bit          m_busy;
  int          m_age;
  logic [31:0] m_inst;
  logic        m_err;
  int          deliveries = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void decode(input logic [31:0] a, output bit err, output int unsigned idx);
    logic [31:0] off;
    off = a - BASE;
    idx = off / 4;
    err = (a % 4 != 0) || (idx >= WORDS);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_inst = 32'h0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge();
    bit          e;
    int unsigned ix;
    if (!rst) return;
    if (m_busy) begin
      if (flush) m_busy = 1'b0;
      else if (m_age >= LAT - 1 && rsp_ready) begin
        m_busy = 1'b0;
        deliveries++;
      end else m_age++;
    end else if (req_valid) begin
      decode(req_addr, e, ix);
      m_err  = e;
      m_inst = e ? 32'h0 : mmem[ix];
      m_busy = 1'b1;
      m_age  = 0;
    end
    if (load_en) begin
      decode(load_addr, e, ix);
      if (!e) mmem[ix] = load_data;
    end
  endtask

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst) begin
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_inst", rsp_inst, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
      end else begin
        check("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, (m_busy && m_age >= LAT - 1)});
        if (m_busy && m_age >= LAT - 1) begin
          check("rsp_inst", rsp_inst, m_inst);
          check("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(string name);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) begin
      miscompares++;
      $display("FAIL %s: rsp_valid timeout got 0 expected 1", name);
    end
  endtask

  // Single fetch with rsp_ready high and literal expected results.
  task automatic fetch_one(string name, logic [31:0] a, logic exp_err, logic [31:0] exp_inst);
    req_valid = 1'b1;
    req_addr  = a;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_valid(name);
    check({name, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
    check({name, "_inst"}, rsp_inst, exp_inst);
    tick();
  endtask

  initial begin
    logic [31:0] w0;
    logic [31:0] w2;
    int          r;
    int unsigned ix;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = 32'h0;
    load_data = 32'h0;
    model_reset();
    chk_en = 1'b1;

    // Reset held for three cycles, then released between edges.
    repeat (3) tick();
    check("lit_reset_ready", {31'b0, req_ready}, 32'h0);
    rst = 1'b1;
    #1;
    check("lit_ready_after_release", {31'b0, req_ready}, 32'h1);
    repeat (3) tick();
    check("lit_idle_valid", {31'b0, rsp_valid}, 32'h0);

    // Fill the array; word 0 and word 1 get known constants.
    for (int i = 0; i < WORDS; i++) begin
      load_en   = 1'b1;
      load_addr = BASE + 32'(i * 4);
      load_data = (i == 0) ? 32'h0000_0297 : (i == 1) ? 32'h0000_0413 : $urandom;
      tick();
    end
    // Ignored writes: out of range (would alias word 0) and misaligned.
    load_addr = 32'h8000_1000;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_addr = 32'h8000_0005;
    tick();
    load_en = 1'b0;

    // Basic fetch: valid sampled at T+2, ready back at T+3.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("lit_basic_not_yet", {31'b0, rsp_valid}, 32'h0);
    tick();
    check("lit_basic_valid", {31'b0, rsp_valid}, 32'h1);
    check("lit_basic_inst", rsp_inst, 32'h0000_0413);
    check("lit_basic_err", {31'b0, rsp_err}, 32'h0);
    tick();
    check("lit_basic_ready_again", {31'b0, req_ready}, 32'h1);

    // Error cases and ignored writes.
    fetch_one("misaligned", 32'h8000_0002, 1'b1, 32'h0);
    fetch_one("past_end", 32'h8000_1000, 1'b1, 32'h0);
    fetch_one("wrap_below", 32'h7FFF_FFFC, 1'b1, 32'h0);
    fetch_one("word0_intact", 32'h8000_0000, 1'b0, 32'h0000_0297);

    // Backpressure for five cycles.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      check("lit_bp_valid", {31'b0, rsp_valid}, 32'h1);
      check("lit_bp_inst", rsp_inst, 32'h0000_0413);
      check("lit_bp_ready", {31'b0, req_ready}, 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("lit_bp_done_valid", {31'b0, rsp_valid}, 32'h0);
    check("lit_bp_done_ready", {31'b0, req_ready}, 32'h1);

    // Flush during WAIT.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    tick();
    req_valid = 1'b0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    check("lit_flush_wait_valid", {31'b0, rsp_valid}, 32'h0);
    check("lit_flush_wait_ready", {31'b0, req_ready}, 32'h1);
    tick();
    check("lit_flush_wait_stays", {31'b0, rsp_valid}, 32'h0);

    // Flush during RESP with rsp_ready high: no delivery.
    r = deliveries;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("lit_flush_resp_pre", {31'b0, rsp_valid}, 32'h1);
    flush     = 1'b1;
    rsp_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("lit_flush_resp_valid", {31'b0, rsp_valid}, 32'h0);
    check("lit_flush_resp_ready", {31'b0, req_ready}, 32'h1);
    check("lit_flush_no_delivery", 32'(deliveries), 32'(r));
    fetch_one("after_flush", 32'h8000_0000, 1'b0, 32'h0000_0297);

    // Fetch and write to the same word on the same edge returns the old word.
    w2        = mmem[2];
    req_valid = 1'b1;
    req_addr  = 32'h8000_0008;
    load_en   = 1'b1;
    load_addr = 32'h8000_0008;
    load_data = ~w2;
    tick();
    req_valid = 1'b0;
    load_en   = 1'b0;
    wait_valid("same_edge");
    check("same_edge_old_word", rsp_inst, w2);
    tick();
    fetch_one("same_edge_new_word", 32'h8000_0008, 1'b0, ~w2);

    // Asynchronous reset in WAIT, between clock edges.
    req_valid = 1'b1;
    req_addr  = 32'h8000_0004;
    tick();
    req_valid = 1'b0;
    #2;
    check("lit_async_pre_ready", {31'b0, req_ready}, 32'h0);
    rst = 1'b0;
    model_reset();
    #1;
    check("lit_async_valid", {31'b0, rsp_valid}, 32'h0);
    check("lit_async_ready", {31'b0, req_ready}, 32'h0);
    check("lit_async_inst", rsp_inst, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    fetch_one("after_async", 32'h8000_0004, 1'b0, 32'h0000_0413);

    // Randomized traffic checked by the compare process.
    w0 = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      ix = $urandom_range(0, WORDS - 1);
      r  = $urandom_range(0, 9);
      if (r == 0) req_addr = BASE + ix * 4 + $urandom_range(1, 3);
      else if (r == 1) req_addr = BASE + WORDS * 4 + $urandom_range(0, 255) * 4;
      else if (r == 2) req_addr = BASE - 4 * $urandom_range(1, 64);
      else req_addr = BASE + ix * 4;
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      load_en   = ($urandom_range(0, 4) == 0);
      load_addr = ($urandom_range(0, 7) == 0) ? (BASE + WORDS * 4 + 32'(ix * 4))
                                              : (BASE + 32'($urandom_range(0, WORDS - 1) * 4));
      load_data = $urandom;
      tick();
      w0 = w0 + 32'(rsp_valid);
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    load_en   = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) tick();
    if (w0 == 0) begin
      miscompares++;
      $display("FAIL random_activity: got %0d responses expected nonzero", w0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
